// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the fp_mul arbiter slice.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100
    } r_mode_t;

    localparam logic [31:0] FP_QNAN = 32'h7fc0_0000;
    localparam logic [31:0] FP_PINF = 32'h7f80_0000;

    // Bit positions inside resp_flags = {bad_rm, nan, ovrf, udrf}
    localparam int FLAG_UDRF   = 0;
    localparam int FLAG_OVRF   = 1;
    localparam int FLAG_NAN    = 2;
    localparam int FLAG_BAD_RM = 3;

    // Encodings above RMM have no defined rounding behaviour.
    function automatic logic rm_legal(input logic [2:0] rm);
        return rm <= 3'(RMM);
    endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// Requester, multiplier and response signals of the shared fp_mul arbiter.
interface fp_mul_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_fp_X;
    logic [NUM_REQ*32-1:0] req_fp_Y;
    logic [NUM_REQ*3-1:0]  req_r_mode;

    logic [31:0]           mul_fp_X;
    logic [31:0]           mul_fp_Y;
    logic [2:0]            mul_r_mode;
    logic [31:0]           mul_fp_Z;
    logic                  mul_ovrf;
    logic                  mul_udrf;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_fp_Z;
    logic [3:0]            resp_flags;

    logic                  busy;

    // Arbiter side
    modport slave (
        input  req_valid, req_fp_X, req_fp_Y, req_r_mode,
        input  mul_fp_Z, mul_ovrf, mul_udrf, resp_ready,
        output req_ready, mul_fp_X, mul_fp_Y, mul_r_mode,
        output resp_valid, resp_id, resp_fp_Z, resp_flags, busy
    );

    // Requesters, multiplier and consumer side
    modport master (
        output req_valid, req_fp_X, req_fp_Y, req_r_mode,
        output mul_fp_Z, mul_ovrf, mul_udrf, resp_ready,
        input  req_ready, mul_fp_X, mul_fp_Y, mul_r_mode,
        input  resp_valid, resp_id, resp_fp_Z, resp_flags, busy
    );

endinterface

// File: rtl/fp_rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer, searching upward with wrap.
module fp_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    input  logic               i_en,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx
);

    logic w_found;

    // Scan the requesters starting at the pointer; first hit wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (i_en && !w_found && i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
                o_grant[(int'(i_ptr) + k) % NUM_REQ] = 1'b1;
                o_idx   = ID_W'((int'(i_ptr) + k) % NUM_REQ);
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Shares one combinational fp_mul among NUM_REQ requesters, one operation at a time.
//
//   state | meaning
//   IDLE  | waiting for any req_valid; grant and latch operands on handshake
//   EXEC  | operands on mul_*, multiplier output settling; capture at edge
//   RESP  | result presented on resp_*; may accept next request when resp_ready
import fp_mul_pkg::*;

module fp_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    fp_mul_arbiter_if.slave  bus
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_tag;
    logic [ID_W-1:0]    r_resp_id;
    logic [31:0]        r_mul_x;
    logic [31:0]        r_mul_y;
    logic [2:0]         r_mul_rm;
    logic               r_bad_rm;
    logic [31:0]        r_resp_z;
    logic [3:0]         r_resp_flags;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_arb_en;
    logic               w_fire;
    logic               w_resp_valid;
    logic               w_busy;
    logic [31:0]        w_sel_x;
    logic [31:0]        w_sel_y;
    logic [2:0]         w_sel_rm;

    // A new operation can only enter when the multiplier slot is free or being freed this cycle.
    assign w_arb_en = (r_state == IDLE) || ((r_state == RESP) && bus.resp_ready);

    fp_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (bus.req_valid),
        .i_ptr   (r_ptr),
        .i_en    (w_arb_en),
        .o_grant (w_gnt),
        .o_idx   (w_gnt_idx)
    );

    assign w_fire        = |w_gnt;
    assign bus.req_ready = w_gnt;

    assign w_sel_x   = bus.req_fp_X[{w_gnt_idx, 5'd0} +: 32];
    assign w_sel_y   = bus.req_fp_Y[{w_gnt_idx, 5'd0} +: 32];
    assign w_sel_rm  = bus.req_r_mode[int'(w_gnt_idx) * 3 +: 3];
    assign w_ptr_nxt = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_resp_valid = 1'b0;
        w_busy       = 1'b1;
        unique case (r_state)
            IDLE: begin
                w_busy = 1'b0;
                if (w_fire) w_state_nxt = EXEC;
            end
            EXEC: w_state_nxt = RESP;
            RESP: begin
                w_resp_valid = 1'b1;
                if (bus.resp_ready) w_state_nxt = w_fire ? EXEC : IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Issue side: latch operands, tag and advance the pointer on a request handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_x  <= '0;
            r_mul_y  <= '0;
            r_mul_rm <= 3'(RNE);
            r_bad_rm <= 1'b0;
            r_tag    <= '0;
            r_ptr    <= '0;
        end else if (w_fire) begin
            r_mul_x  <= w_sel_x;
            r_mul_y  <= w_sel_y;
            r_mul_rm <= rm_legal(w_sel_rm) ? w_sel_rm : 3'(RNE);
            r_bad_rm <= !rm_legal(w_sel_rm);
            r_tag    <= w_gnt_idx;
            r_ptr    <= w_ptr_nxt;
        end
    end

    // Result side: capture the settled multiplier output at the end of EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_z     <= '0;
            r_resp_flags <= '0;
            r_resp_id    <= '0;
        end else if (r_state == EXEC) begin
            r_resp_z                  <= bus.mul_fp_Z;
            r_resp_flags[FLAG_BAD_RM] <= r_bad_rm;
            r_resp_flags[FLAG_NAN]    <= (bus.mul_fp_Z == FP_QNAN);
            r_resp_flags[FLAG_OVRF]   <= bus.mul_ovrf;
            r_resp_flags[FLAG_UDRF]   <= bus.mul_udrf;
            r_resp_id                 <= r_tag;
        end
    end

    assign bus.mul_fp_X   = r_mul_x;
    assign bus.mul_fp_Y   = r_mul_y;
    assign bus.mul_r_mode = r_mul_rm;
    assign bus.resp_valid = w_resp_valid;
    assign bus.resp_id    = r_resp_id;
    assign bus.resp_fp_Z  = r_resp_z;
    assign bus.resp_flags = r_resp_flags;
    assign bus.busy       = w_busy;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: stub multiplier, negedge reference model with scoreboard,
// a table of single-operation vectors and hand-written multi-cycle sequences.
module tb_fp_mul_arbiter;
    import fp_mul_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_mul_arbiter_if #(.NUM_REQ(N)) bus();

    fp_mul_arbiter #(.NUM_REQ(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the shared multiplier: known products for the test values,
    // an arbitrary deterministic mix otherwise. Returns {ovrf, udrf, Z}.
    function automatic logic [33:0] stub_mul(input logic [31:0] x, input logic [31:0] y);
        if (x == 32'h4040_0000 && y == 32'h4040_0000) return {2'b00, 32'h4110_0000};
        if ((x == FP_PINF && y == 32'h0) || (x == 32'h0 && y == FP_PINF)) return {2'b00, FP_QNAN};
        if (x == 32'h7f00_0000 && y == 32'h7f00_0000) return {2'b10, FP_PINF};
        if (x == 32'h3f80_0000 && y == 32'h3f80_0000) return {2'b00, 32'h3f80_0000};
        if (x == 32'h0080_0000 && y == 32'h0080_0000) return {2'b01, 32'h0};
        return {2'b00, x ^ y ^ 32'h5a5a_0000};
    endfunction

    always_comb begin
        {bus.mul_ovrf, bus.mul_udrf, bus.mul_fp_Z} = stub_mul(bus.mul_fp_X, bus.mul_fp_Y);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [31:0] id;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] z;
        logic [3:0]  fl;
    } exp_t;

    typedef enum {M_IDLE, M_EXEC, M_RESP} m_state_t;

    exp_t        sb[$];
    m_state_t    m_state;
    int          m_ptr;
    int          m_idx;
    logic [N-1:0] m_g;

    always @(negedge clk) begin
        if (rst) begin
            m_state = M_IDLE;
            m_ptr   = 0;
            sb.delete();
        end else begin
            exp_t        e;
            logic [33:0] s;
            m_g   = '0;
            m_idx = -1;
            if (m_state == M_IDLE || (m_state == M_RESP && bus.resp_ready)) begin
                for (int k = 0; k < N; k++) begin
                    if (m_idx < 0 && bus.req_valid[(m_ptr + k) % N]) m_idx = (m_ptr + k) % N;
                end
            end
            if (m_idx >= 0) m_g[m_idx] = 1'b1;

            chk("req_ready", 32'(bus.req_ready), 32'(m_g));
            chk("resp_valid", 32'(bus.resp_valid), 32'(m_state == M_RESP));
            chk("busy", 32'(bus.busy), 32'(m_state != M_IDLE));

            if (m_state == M_EXEC) begin
                chk("sb_depth_exec", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    chk("mul_fp_X", bus.mul_fp_X, sb[0].x);
                    chk("mul_fp_Y", bus.mul_fp_Y, sb[0].y);
                    chk("mul_r_mode", 32'(bus.mul_r_mode), 32'(sb[0].rm));
                end
            end

            if (m_state == M_RESP && bus.resp_ready) begin
                chk("sb_depth_resp", 32'(sb.size()), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("sb_resp_id", 32'(bus.resp_id), e.id);
                    chk("sb_resp_fp_Z", bus.resp_fp_Z, e.z);
                    chk("sb_resp_flags", 32'(bus.resp_flags), 32'(e.fl));
                end
            end

            if (m_idx >= 0) begin
                e.id = 32'(m_idx);
                e.x  = bus.req_fp_X[32*m_idx +: 32];
                e.y  = bus.req_fp_Y[32*m_idx +: 32];
                e.rm = bus.req_r_mode[3*m_idx +: 3];
                s    = stub_mul(e.x, e.y);
                e.z  = s[31:0];
                e.fl = {(e.rm > 3'd4), (s[31:0] == 32'h7fc0_0000), s[33], s[32]};
                if (e.rm > 3'd4) e.rm = 3'b000;
                sb.push_back(e);
                m_ptr = (m_idx + 1) % N;
            end

            case (m_state)
                M_IDLE:  if (m_idx >= 0) m_state = M_EXEC;
                M_EXEC:  m_state = M_RESP;
                default: if (bus.resp_ready) m_state = (m_idx >= 0) ? M_EXEC : M_IDLE;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
        bus.req_fp_X[32*i +: 32] = x;
        bus.req_fp_Y[32*i +: 32] = y;
        bus.req_r_mode[3*i +: 3] = rm;
        bus.req_valid[i]         = 1'b1;
    endtask

    // Returns just after the accepting edge (DUT in EXEC) and drops that requester's valid.
    task automatic wait_accept(input int i, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (bus.req_ready[i]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        if (ok) bus.req_valid[i] = 1'b0;
    endtask

    task automatic wait_resp(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20 && !ok; c++) begin
            if (bus.resp_valid) ok = 1'b1;
            else tick();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int          req;
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  rm;
        logic [31:0] z;
        logic [3:0]  fl;
        logic [2:0]  mrm;
    } vec_t;

    vec_t tv[6];

    initial begin
        bit          ok;
        int          last;
        logic [31:0] cap_z;
        logic [31:0] cap_id;
        logic [31:0] cap_fl;

        tv[0] = '{0, 32'h4040_0000, 32'h4040_0000, 3'b001, 32'h4110_0000, 4'b0000, 3'b001};
        tv[1] = '{2, 32'h7f80_0000, 32'h0000_0000, 3'b000, 32'h7fc0_0000, 4'b0100, 3'b000};
        tv[2] = '{1, 32'h7f00_0000, 32'h7f00_0000, 3'b000, 32'h7f80_0000, 4'b0010, 3'b000};
        tv[3] = '{3, 32'h3f80_0000, 32'h3f80_0000, 3'b111, 32'h3f80_0000, 4'b1000, 3'b000};
        tv[4] = '{0, 32'h0080_0000, 32'h0080_0000, 3'b100, 32'h0000_0000, 4'b0001, 3'b100};
        tv[5] = '{1, 32'h3f80_0000, 32'h3f80_0000, 3'b101, 32'h3f80_0000, 4'b1000, 3'b000};

        rst              = 1'b1;
        bus.req_valid    = '0;
        bus.req_fp_X     = '0;
        bus.req_fp_Y     = '0;
        bus.req_r_mode   = '0;
        bus.resp_ready   = 1'b1;
        repeat (3) tick();

        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rst_resp_fp_Z", bus.resp_fp_Z, 32'd0);
        chk("rst_resp_flags", 32'(bus.resp_flags), 32'd0);
        chk("rst_mul_fp_X", bus.mul_fp_X, 32'd0);
        chk("rst_mul_r_mode", 32'(bus.mul_r_mode), 32'd0);
        rst = 1'b0;
        tick();

        // Single operations from the table.
        for (int v = 0; v < 6; v++) begin
            set_req(tv[v].req, tv[v].x, tv[v].y, tv[v].rm);
            wait_accept(tv[v].req, ok);
            chk("tv_accept", 32'(ok), 32'd1);
            chk("tv_exec_mul_r_mode", 32'(bus.mul_r_mode), 32'(tv[v].mrm));
            chk("tv_exec_no_resp", 32'(bus.resp_valid), 32'd0);
            tick();
            chk("tv_latency", 32'(bus.resp_valid), 32'd1);
            chk("tv_resp_id", 32'(bus.resp_id), 32'(tv[v].req));
            chk("tv_resp_fp_Z", bus.resp_fp_Z, tv[v].z);
            chk("tv_resp_flags", 32'(bus.resp_flags), 32'(tv[v].fl));
            tick();
        end

        // Reset while an operation sits in EXEC.
        set_req(2, 32'h4040_0000, 32'h3f80_0000, 3'b010);
        wait_accept(2, ok);
        chk("rx_accept", 32'(ok), 32'd1);
        chk("rx_in_exec", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rx_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rx_busy", 32'(bus.busy), 32'd0);
        chk("rx_resp_id", 32'(bus.resp_id), 32'd0);
        chk("rx_resp_fp_Z", bus.resp_fp_Z, 32'd0);
        chk("rx_resp_flags", 32'(bus.resp_flags), 32'd0);
        chk("rx_mul_fp_X", bus.mul_fp_X, 32'd0);
        chk("rx_mul_fp_Y", bus.mul_fp_Y, 32'd0);
        chk("rx_mul_r_mode", 32'(bus.mul_r_mode), 32'd0);
        repeat (3) begin
            tick();
            chk("rx_no_resp", 32'(bus.resp_valid), 32'd0);
        end

        // All requesters valid: rotation from 0 and one response every 2 cycles.
        for (int i = 0; i < N; i++) set_req(i, 32'h4000_0000 + (32'(i) << 20), 32'h3fc0_0000, 3'(i));
        last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_resp(ok);
            chk("rr_resp_seen", 32'(ok), 32'd1);
            chk("rr_id", 32'(bus.resp_id), 32'(k % N));
            if (k > 0) chk("rr_gap", 32'(cyc - last), 32'd2);
            last = cyc;
            if (k == 4) bus.req_valid = '0;
            tick();
        end
        repeat (2) tick();

        // Backpressure: hold resp_ready low, then release into a back-to-back issue.
        bus.resp_ready = 1'b0;
        set_req(0, 32'h4040_0000, 32'h4040_0000, 3'b011);
        set_req(1, 32'h7f00_0000, 32'h7f00_0000, 3'b000);
        wait_resp(ok);
        chk("bp_resp_seen", 32'(ok), 32'd1);
        bus.req_valid[1] = 1'b0;
        chk("bp_id", 32'(bus.resp_id), 32'd1);
        chk("bp_fp_Z", bus.resp_fp_Z, 32'h7f80_0000);
        chk("bp_flags", 32'(bus.resp_flags), 32'b0010);
        cap_z  = bus.resp_fp_Z;
        cap_id = 32'(bus.resp_id);
        cap_fl = 32'(bus.resp_flags);
        repeat (5) begin
            tick();
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_hold_id", 32'(bus.resp_id), cap_id);
            chk("bp_hold_fp_Z", bus.resp_fp_Z, cap_z);
            chk("bp_hold_flags", 32'(bus.resp_flags), cap_fl);
            chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        #1;
        chk("b2b_req_ready", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = '0;
        chk("b2b_exec_busy", 32'(bus.busy), 32'd1);
        chk("b2b_exec_valid", 32'(bus.resp_valid), 32'd0);
        tick();
        chk("b2b_resp_valid", 32'(bus.resp_valid), 32'd1);
        chk("b2b_resp_id", 32'(bus.resp_id), 32'd0);
        chk("b2b_resp_fp_Z", bus.resp_fp_Z, 32'h4110_0000);
        chk("b2b_resp_flags", 32'(bus.resp_flags), 32'd0);
        repeat (4) tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        chk("final_idle", 32'(bus.busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
